// File: rtl/key_event_pkg.sv
// Shared types for the key event sequencer: event codes, scan states and the
// event record carried through the event FIFO.
package key_event_pkg;

  localparam int KEY_NUM = 16;
  localparam int KEY_IW  = $clog2(KEY_NUM);

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_REPEAT  = 2'd2,
    EV_FAULT   = 2'd3
  } ev_code_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_REP
  } scan_state_t;

  typedef struct packed {
    ev_code_t          code;
    logic [KEY_IW-1:0] index;
  } key_event_t;

  function automatic ev_code_t edge_code(input logic lvl);
    return lvl ? EV_PRESS : EV_RELEASE;
  endfunction

endpackage

// File: rtl/key_event_ctrl_fifo.sv
// Show-ahead event FIFO: the head entry is presented on data_o whenever the
// FIFO is non-empty. Pointers wrap naturally because DEPTH is a power of two.
module event_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 6,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full/empty come from the registered level, so a same-cycle pop never
  // makes room for a push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event sequencer: sweeps the filtered key vector, emits PRESS/RELEASE/
// FAULT per index plus an autorepeat REPEAT, and queues them for the CPU.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter  int NUM        = KEY_NUM,
  parameter  int FIFO_DEPTH = 8,
  parameter  int REP_DELAY  = 500,
  parameter  int REP_PERIOD = 100,
  localparam int IW         = $clog2(NUM),
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           sclr_n,
  input  logic           tick,
  input  logic [NUM-1:0] key,
  input  logic [NUM-1:0] ready,
  input  logic [NUM-1:0] timeout,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [1:0]     ev_code,
  output logic [IW-1:0]  ev_index,
  output logic           busy,
  output logic [LW-1:0]  level
);

  localparam int EW = $bits(key_event_t);

  scan_state_t    state_q;
  logic [IW-1:0]  idx_q;
  logic [NUM-1:0] known_q, snap_q, snf_q;
  logic [NUM-1:0] fault_rep_q, fault_rep_d, fault_set;
  logic [IW-1:0]  rep_key_q, rep_key_d;
  logic           rep_active_q, rep_active_d;
  logic           rep_due_q, rep_due_d;
  logic [15:0]    rep_cnt_q, rep_cnt_d;

  logic [NUM-1:0] eff, nf;
  logic           push_req, push_go, stall;
  key_event_t     push_ev, head_ev;
  logic [EW-1:0]  head_bits;
  logic           fifo_full, fifo_empty;

  assign eff = key & ready & ~timeout;
  assign nf  = timeout & ~fault_rep_q;

  // A pending fault on an index takes the slot; its level edge is seen on a
  // later sweep.
  always_comb begin
    push_req      = 1'b0;
    push_ev.code  = EV_PRESS;
    push_ev.index = idx_q;
    case (state_q)
      S_SCAN: begin
        if (snf_q[idx_q]) begin
          push_req     = 1'b1;
          push_ev.code = EV_FAULT;
        end else if (snap_q[idx_q] != known_q[idx_q]) begin
          push_req     = 1'b1;
          push_ev.code = edge_code(snap_q[idx_q]);
        end
      end
      S_REP: begin
        if (rep_due_q) begin
          push_req      = 1'b1;
          push_ev.code  = EV_REPEAT;
          push_ev.index = rep_key_q;
        end
      end
      default: ;
    endcase
  end

  assign push_go = push_req & ~fifo_full;
  assign stall   = push_req & fifo_full;

  always_comb begin
    fault_set = '0;
    if (push_go && push_ev.code == EV_FAULT) fault_set[idx_q] = 1'b1;
    fault_rep_d = (fault_rep_q | fault_set) & timeout;
  end

  // Tick countdown first; any event pushed this cycle overrides it.
  always_comb begin
    rep_key_d    = rep_key_q;
    rep_active_d = rep_active_q;
    rep_due_d    = rep_due_q;
    rep_cnt_d    = rep_cnt_q;
    if (tick && rep_active_q && !rep_due_q && REP_PERIOD != 0) begin
      if (rep_cnt_q <= 16'd1) rep_due_d = 1'b1;
      else                    rep_cnt_d = rep_cnt_q - 16'd1;
    end
    if (push_go) begin
      case (push_ev.code)
        EV_PRESS: begin
          rep_key_d    = idx_q;
          rep_active_d = 1'b1;
          rep_cnt_d    = 16'(REP_DELAY);
          rep_due_d    = 1'b0;
        end
        EV_RELEASE, EV_FAULT: begin
          if (idx_q == rep_key_q) begin
            rep_active_d = 1'b0;
            rep_due_d    = 1'b0;
          end
        end
        EV_REPEAT: begin
          rep_due_d = 1'b0;
          rep_cnt_d = 16'(REP_PERIOD);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      known_q <= '0;
      snap_q  <= '0;
      snf_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((eff != known_q) || (|nf) || rep_due_q) begin
            snap_q  <= eff;
            snf_q   <= nf;
            idx_q   <= '0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!stall) begin
            if (push_go && !snf_q[idx_q]) known_q[idx_q] <= snap_q[idx_q];
            if (idx_q == IW'(NUM - 1)) state_q <= S_REP;
            else                       idx_q   <= idx_q + IW'(1);
          end
        end
        S_REP: begin
          if (!stall) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      fault_rep_q  <= '0;
      rep_key_q    <= '0;
      rep_active_q <= 1'b0;
      rep_due_q    <= 1'b0;
      rep_cnt_q    <= '0;
    end else begin
      fault_rep_q  <= fault_rep_d;
      rep_key_q    <= rep_key_d;
      rep_active_q <= rep_active_d;
      rep_due_q    <= rep_due_d;
      rep_cnt_q    <= rep_cnt_d;
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .sclr_n  (sclr_n),
    .push_i  (push_go),
    .data_i  (push_ev),
    .full_o  (fifo_full),
    .pop_i   (ev_ready),
    .data_o  (head_bits),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign head_ev  = key_event_t'(head_bits);
  assign ev_valid = ~fifo_empty;
  assign ev_code  = head_ev.code;
  assign ev_index = head_ev.index;
  assign busy     = (state_q != S_IDLE);

endmodule
